// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIF unit controller.
package fir_xifu_pkg;

   localparam int unsigned X_ID_WIDTH = 3;
   localparam int unsigned X_ID_MAX   = 8;
   localparam int unsigned CNT_W      = $clog2(X_ID_MAX + 1);

   typedef struct packed {
      logic                  issue;
      logic [X_ID_WIDTH-1:0] id;
   } fir_xifu_id2ctrl_t;

   typedef struct packed {
      logic [X_ID_MAX-1:0] clear;
   } fir_xifu_wb2ctrl_t;

   typedef struct packed {
      logic [X_ID_MAX-1:0] issue;
      logic [X_ID_MAX-1:0] commit;
      logic [X_ID_MAX-1:0] kill;
   } fir_xifu_ctrl2wb_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUED    = 2'd1,
      ST_COMMITTED = 2'd2,
      ST_KILLED    = 2'd3
   } fir_xifu_ctrl_state_t;

   function automatic logic [CNT_W-1:0] popcnt(input logic [X_ID_MAX-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(X_ID_MAX); i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/fir_xifu_ctrl_slot.sv
// Lifecycle FSM for a single XIF instruction ID.
//   state        | meaning
//   ST_IDLE      | ID free, may be issued
//   ST_ISSUED    | issued, waiting for commit or kill
//   ST_COMMITTED | committed, waiting for writeback clear
//   ST_KILLED    | killed, waiting for writeback clear
module fir_xifu_ctrl_slot
   import fir_xifu_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 issue_i,
   input  logic                 commit_i,
   input  logic                 kill_i,
   input  logic                 clear_i,
   output fir_xifu_ctrl_state_t state_o
);

   fir_xifu_ctrl_state_t state_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            // An issue and its commit may land together; go straight to the outcome.
            ST_IDLE:
               if (issue_i) state_q <= commit_i ? (kill_i ? ST_KILLED : ST_COMMITTED) : ST_ISSUED;
            ST_ISSUED:
               if (clear_i)       state_q <= ST_IDLE;
               else if (commit_i) state_q <= kill_i ? ST_KILLED : ST_COMMITTED;
            default:
               if (clear_i) state_q <= ST_IDLE;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/fir_xifu_ctrl.sv
// FIR XIF unit issue/commit/writeback ID tracker with outstanding counter.
// Define FIR_XIFU_CTRL_ERR_EN to add the sticky protocol-violation flag err_o.
module fir_xifu_ctrl
   import fir_xifu_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = X_ID_MAX
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  fir_xifu_id2ctrl_t     id2ctrl_i,
   output logic                  issue_ready_o,
   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,
   input  fir_xifu_wb2ctrl_t     wb2ctrl_i,
   output fir_xifu_ctrl2wb_t     ctrl2wb_o,
`ifdef FIR_XIFU_CTRL_ERR_EN
   output logic                  err_o,
`endif
   output logic                  busy_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   fir_xifu_ctrl_state_t st [X_ID_MAX];
   logic [X_ID_MAX-1:0]  idle_v;
   logic [X_ID_MAX-1:0]  clr_valid;
   logic                 accept;
   logic [CNT_W-1:0]     count_q, count_d;

   assign issue_ready_o = (st[id2ctrl_i.id] == ST_IDLE) && (count_q != MAX_CNT);
   assign accept        = id2ctrl_i.issue && issue_ready_o;

   for (genvar g = 0; g < int'(X_ID_MAX); g++) begin : g_slot
      fir_xifu_ctrl_slot u_slot (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .issue_i (accept && (id2ctrl_i.id == X_ID_WIDTH'(g))),
         .commit_i(commit_valid_i && (commit_id_i == X_ID_WIDTH'(g))),
         .kill_i  (commit_kill_i),
         .clear_i (wb2ctrl_i.clear[g]),
         .state_o (st[g])
      );
   end

   always_comb begin
      ctrl2wb_o = '0;
      idle_v    = '0;
      for (int i = 0; i < int'(X_ID_MAX); i++) begin
         idle_v[i]           = (st[i] == ST_IDLE);
         ctrl2wb_o.issue[i]  = (st[i] != ST_IDLE);
         ctrl2wb_o.commit[i] = (st[i] == ST_COMMITTED);
         ctrl2wb_o.kill[i]   = (st[i] == ST_KILLED);
      end
   end

   // Clears of already-idle IDs must not decrement the count.
   assign clr_valid = wb2ctrl_i.clear & ~idle_v;
   assign count_d   = count_q + CNT_W'(accept) - popcnt(clr_valid);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign busy_o = (count_q != '0);

`ifdef FIR_XIFU_CTRL_ERR_EN
   logic err_q, viol;

   assign viol = (commit_valid_i && (st[commit_id_i] != ST_ISSUED)
                    && !(accept && (id2ctrl_i.id == commit_id_i)))
              || (|(wb2ctrl_i.clear & idle_v))
              || (id2ctrl_i.issue && !issue_ready_o);

   always_ff @(posedge clk_i) begin
      if (!rst_ni)   err_q <= 1'b0;
      else if (viol) err_q <= 1'b1;
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed scoreboard bench: two controllers (full depth and depth 2) driven in lockstep.
module tb_fir_xifu_ctrl;
   import fir_xifu_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   fir_xifu_id2ctrl_t     id2ctrl;
   logic                  commit_valid;
   logic [X_ID_WIDTH-1:0] commit_id;
   logic                  commit_kill;
   fir_xifu_wb2ctrl_t     wb2ctrl;
   logic                  ready [2];
   fir_xifu_ctrl2wb_t     c2w   [2];
   logic                  busy  [2];
   logic                  err   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fir_xifu_ctrl #(.MAX_OUTSTANDING(X_ID_MAX)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .id2ctrl_i(id2ctrl), .issue_ready_o(ready[0]),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .wb2ctrl_i(wb2ctrl), .ctrl2wb_o(c2w[0]),
`ifdef FIR_XIFU_CTRL_ERR_EN
      .err_o(err[0]),
`endif
      .busy_o(busy[0]));

   fir_xifu_ctrl #(.MAX_OUTSTANDING(2)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .id2ctrl_i(id2ctrl), .issue_ready_o(ready[1]),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .wb2ctrl_i(wb2ctrl), .ctrl2wb_o(c2w[1]),
`ifdef FIR_XIFU_CTRL_ERR_EN
      .err_o(err[1]),
`endif
      .busy_o(busy[1]));

`ifndef FIR_XIFU_CTRL_ERR_EN
   assign err[0] = 1'b0;
   assign err[1] = 1'b0;
`endif

   typedef struct {
      string      tag;
      int         inst;
      logic [7:0] iss, com, kil;
      logic       bsy;
      int         cnt;
      logic       er;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state, one copy per instance
   logic [1:0] m_st  [2][8];
   int         m_cnt [2];
   logic       m_err [2];
   int         m_max [2] = '{8, 2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic iss, input int id,
                       input logic cv, input int cid, input logic ck, input logic [7:0] clr);
      exp_t       e;
      logic [1:0] ns [8];
      logic       rdy, acc, viol;
      int         ncl;
      rst_n          = ~rst;
      id2ctrl.issue  = iss;
      id2ctrl.id     = X_ID_WIDTH'(id);
      commit_valid   = cv;
      commit_id      = X_ID_WIDTH'(cid);
      commit_kill    = ck;
      wb2ctrl.clear  = clr;
      #1;
      for (int k = 0; k < 2; k++) begin
         rdy = (m_st[k][id] == 2'd0) && (m_cnt[k] != m_max[k]);
         if (!rst) chk($sformatf("%s_ready%0d", tag, k), 32'(ready[k]), 32'(rdy));
         acc  = iss && rdy;
         viol = (iss && !rdy)
             || (cv && m_st[k][cid] != 2'd1 && !(acc && id == cid));
         ncl  = 0;
         for (int i = 0; i < 8; i++) begin
            ns[i] = m_st[k][i];
            if (clr[i] && m_st[k][i] == 2'd0) viol = 1'b1;
            if (clr[i] && m_st[k][i] != 2'd0) begin
               ns[i] = 2'd0;
               ncl++;
            end else if (m_st[k][i] == 2'd1 && cv && cid == i) begin
               ns[i] = ck ? 2'd3 : 2'd2;
            end else if (m_st[k][i] == 2'd0 && acc && id == i) begin
               ns[i] = (cv && cid == i) ? (ck ? 2'd3 : 2'd2) : 2'd1;
            end
         end
         if (rst) begin
            for (int i = 0; i < 8; i++) ns[i] = 2'd0;
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
         end else begin
            m_cnt[k] = m_cnt[k] + (acc ? 1 : 0) - ncl;
            m_err[k] = m_err[k] | viol;
         end
         e.tag  = tag;
         e.inst = k;
         for (int i = 0; i < 8; i++) begin
            m_st[k][i] = ns[i];
            e.iss[i]   = (ns[i] != 2'd0);
            e.com[i]   = (ns[i] == 2'd2);
            e.kil[i]   = (ns[i] == 2'd3);
         end
         e.bsy = (m_cnt[k] != 0);
         e.cnt = m_cnt[k];
         e.er  = m_err[k];
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("%s_iss%0d", e.tag, e.inst), 32'(c2w[e.inst].issue),  32'(e.iss));
         chk($sformatf("%s_com%0d", e.tag, e.inst), 32'(c2w[e.inst].commit), 32'(e.com));
         chk($sformatf("%s_kil%0d", e.tag, e.inst), 32'(c2w[e.inst].kill),   32'(e.kil));
         chk($sformatf("%s_busy%0d", e.tag, e.inst), 32'(busy[e.inst]), 32'(e.bsy));
         chk($sformatf("%s_cnt%0d", e.tag, e.inst),
             32'(e.inst == 0 ? u_dut0.count_q : u_dut1.count_q), 32'(e.cnt));
`ifdef FIR_XIFU_CTRL_ERR_EN
         chk($sformatf("%s_err%0d", e.tag, e.inst), 32'(err[e.inst]), 32'(e.er));
`endif
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_err[k] = 1'b0;
         for (int i = 0; i < 8; i++) m_st[k][i] = 2'd0;
      end
      step("rst_a", 1, 0, 0, 0, 0, 0, 8'h00);
      step("rst_b", 1, 0, 0, 0, 0, 0, 8'h00);
      step("idle",  0, 0, 0, 0, 0, 0, 8'h00);

      // issue -> commit -> clear lifecycle on id 3
      step("s30_iss",  0, 1, 3, 0, 0, 0, 8'h00);
      chk("s30_issue3_set", 32'(c2w[0].issue[3]), 32'd1);
      step("s30_com",  0, 0, 0, 1, 3, 0, 8'h00);
      chk("s30_commit3_set", 32'(c2w[0].commit[3]), 32'd1);
      step("s30_recom", 0, 0, 0, 1, 3, 1, 8'h00);
      step("s30_clr",  0, 0, 0, 0, 0, 0, 8'h08);
      chk("s30_busy_low", 32'(busy[0]), 32'd0);

      // same-cycle issue and kill on id 5
      step("s31_isskill", 0, 1, 5, 1, 5, 1, 8'h00);
      chk("s31_kill5", 32'({c2w[0].kill[5], c2w[0].commit[5]}), 32'b10);
      step("s31_clr", 0, 0, 0, 0, 0, 0, 8'h20);

      // outstanding limit on the depth-2 instance
      step("s32_iss0", 0, 1, 0, 0, 0, 0, 8'h00);
      step("s32_iss1", 0, 1, 1, 0, 0, 0, 8'h00);
      id2ctrl.issue = 1'b1;
      id2ctrl.id    = 3'd2;
      #1;
      chk("s32_full_ready", 32'(ready[1]), 32'd0);
      step("s32_iss2", 0, 1, 2, 0, 0, 0, 8'h00);
      step("s32_clr0", 0, 0, 0, 0, 0, 0, 8'h01);
      step("s32_iss2b", 0, 1, 2, 0, 0, 0, 8'h00);
      chk("s32_id2_taken", 32'(c2w[1].issue[2]), 32'd1);
      step("s32_clr12", 0, 0, 0, 0, 0, 0, 8'h06);

      // re-issue of an in-flight id
      step("s33_iss4",  0, 1, 4, 0, 0, 0, 8'h00);
      step("s33_reiss", 0, 1, 4, 0, 0, 0, 8'h00);
`ifdef FIR_XIFU_CTRL_ERR_EN
      chk("s33_err", 32'(err[0]), 32'd1);
`endif

      // double clear with count at 3
      step("s34_iss2", 0, 1, 2, 0, 0, 0, 8'h00);
      step("s34_iss7", 0, 1, 7, 0, 0, 0, 8'h00);
      step("s34_clr",  0, 0, 0, 0, 0, 0, 8'h84);
      chk("s34_cnt1", 32'(u_dut0.count_q), 32'd1);
      step("s34_clr4", 0, 0, 0, 0, 0, 0, 8'h10);

      // mid-operation reset with active inputs
      step("s35_iss0", 0, 1, 0, 0, 0, 0, 8'h00);
      step("s35_iss1", 0, 1, 1, 0, 0, 0, 8'h00);
      step("s35_iss2", 0, 1, 2, 1, 0, 1, 8'h00);
      step("s35_iss3", 0, 1, 3, 0, 0, 0, 8'h00);
      step("s35_rst",  1, 1, 6, 1, 1, 1, 8'h02);
      chk("s35_bitmaps", 32'({c2w[0].issue, c2w[0].commit, c2w[0].kill}), 32'd0);
      step("s35_iss0b", 0, 1, 0, 0, 0, 0, 8'h00);
      chk("s35_id0", 32'(c2w[0].issue), 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_xifu_ctrl.md
FIR_XIFU_CTRL -- requirements
Module: fir_xifu_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default fir_xifu_pkg::X_ID_MAX, meaning the maximum number of simultaneously tracked IDs (range 1..X_ID_MAX).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port id2ctrl_i, input, fir_xifu_id2ctrl_t, carrying the issue request (issue) and its XIF id.
REQ-005 SHALL have port issue_ready_o, output, 1, high when an issue is accepted this cycle.
REQ-006 SHALL have port commit_valid_i, input, 1, the XIF commit strobe.
REQ-007 SHALL have port commit_id_i, input, X_ID_WIDTH, the commit target ID.
REQ-008 SHALL have port commit_kill_i, input, 1, meaning the commit is a kill.
REQ-009 SHALL have port wb2ctrl_i, input, fir_xifu_wb2ctrl_t, a one-hot-per-ID clear from writeback.
REQ-010 SHALL have port ctrl2wb_o, output, fir_xifu_ctrl2wb_t, carrying the per-ID issue, commit and kill bitmaps.
REQ-011 SHALL have port busy_o, output, 1, high when any ID is not IDLE.

Function
REQ-012 SHALL keep a per-ID 2-bit state: IDLE, ISSUED, COMMITTED, KILLED.
REQ-013 SHALL drive issue_ready_o combinationally; it is low if the requested ID is not IDLE or the outstanding count equals MAX_OUTSTANDING, and high otherwise.
REQ-014 SHALL accept an issue when id2ctrl_i.issue and issue_ready_o are both high; the ID moves IDLE->ISSUED and the count increments.
REQ-015 SHALL apply a commit to an ISSUED ID: commit_kill_i=0 moves it to COMMITTED, and commit_kill_i=1 moves it to KILLED.
REQ-016 SHALL ignore a commit to an IDLE, COMMITTED or KILLED ID, leaving its state unchanged.
REQ-017 SHALL act as follows when an issue is accepted and a commit targets the same ID in the same cycle: the ID moves directly IDLE->COMMITTED or IDLE->KILLED.
REQ-018 SHALL move each COMMITTED or KILLED ID whose wb2ctrl_i.clear bit is set to IDLE, and decrement the count by the number cleared.
REQ-019 SHALL allow a clear of an ISSUED ID, which also moves it to IDLE and decrements the count.
REQ-020 SHALL act as follows when a clear and an issue target the same ID in the same cycle: the issue is refused (issue_ready_o evaluates pre-clear state) and the clear takes effect.
REQ-021 SHALL update the outstanding counter as count + accepted_issue - popcount(valid clears) in one cycle; the counter width is clog2(X_ID_MAX+1) and it never wraps.
REQ-022 SHALL decode ctrl2wb_o from registered state: issue[i] = state!=IDLE, commit[i] = COMMITTED, kill[i] = KILLED; events are visible one cycle after they occur.
REQ-023 SHALL assert busy_o exactly when the count is non-zero.

Reset
REQ-024 SHALL, while rst_ni is low at a clock edge, set all IDs to IDLE, the count to 0, ctrl2wb_o to all-zero and busy_o to 0; issue_ready_o then reflects the empty state.
REQ-025 SHALL, when reset occurs mid-operation, discard all in-flight IDs without emitting kill bitmaps; inputs in the reset cycle are ignored.

Configuration
REQ-026 SHALL, with FIR_XIFU_CTRL_ERR_EN defined, add output err_o (1 bit) that is sticky-high one cycle after any violation until reset; a violation is a commit to a non-ISSUED ID, a clear of an IDLE ID, or an issue while not ready.
REQ-027 SHALL, without FIR_XIFU_CTRL_ERR_EN, omit err_o and silently ignore violations per REQ-016, REQ-018 and REQ-020.

Structure
REQ-028 SHALL place the per-ID state enum (fir_xifu_ctrl_state_t) in fir_xifu_pkg, next to the existing id2ctrl, wb2ctrl and ctrl2wb structs and X_ID constants.
REQ-029 SHALL implement the per-ID FSM in one sub-module, fir_xifu_ctrl_slot, instantiated X_ID_MAX times; the counter and ready logic stay in the top module.

Verification
REQ-030 SHALL cover this scenario: issue id 3, then commit id 3 with kill=0, then clear bit 3 -> ctrl2wb issue[3]=1, then commit[3]=1, then all-zero; busy_o returns to 0.
REQ-031 SHALL cover this scenario: issue id 5 and commit id 5 with kill=1 in the same cycle -> next cycle kill[5]=1 and commit[5]=0.
REQ-032 SHALL cover this scenario: MAX_OUTSTANDING=2, issue ids 0 and 1, then request id 2 -> issue_ready_o=0; after clear bit 0, the id 2 issue is accepted.
REQ-033 SHALL cover this scenario: re-issue id 4 while it is ISSUED -> issue_ready_o=0 and the state is unchanged; with FIR_XIFU_CTRL_ERR_EN defined, err_o=1 the next cycle.
REQ-034 SHALL cover this scenario: clear bits 2 and 7 in one cycle with the count at 3 -> the count becomes 1 and both IDs return to IDLE.
REQ-035 SHALL cover this scenario: with 4 IDs in flight, assert rst_ni=0 for one cycle -> all bitmaps are 0, busy_o=0, and issue of id 0 is accepted in the next cycle.
